row_window_feeder: RTL



---
 rtl/row_window_feeder.sv | 112 +++++++++++
 1 files changed

// File: rtl/row_window_feeder.sv
// row_window_feeder: scans a ROWS x WIDTH binary image held in a combinational ROM and
// presents one 3-row window (above/center/below) per image row over a valid/ready handshake.
// Optional macro BORDER_REPLICATE_EN: edge rows replicate the nearest image row instead of
// being padded with zeros. Timing and handshake are identical in both builds.
module row_window_feeder #(
  parameter int unsigned ROWS  = 128,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [AW-1:0]    rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] row_above,
  output logic [WIDTH-1:0] row_center,
  output logic [WIDTH-1:0] row_below,
  output logic [AW-1:0]    row_index,
  output logic             win_valid,
  input  logic             win_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {StIdle, StFill0, StFill1, StEmit, StDone} state_t;

  // rd_ptr carries one extra bit so the end-of-image compare cannot wrap when ROWS == 2**AW
  localparam logic [AW:0]   RowsP   = (AW + 1)'(ROWS);
  localparam logic [AW-1:0] LastRow = AW'(ROWS - 1);

  state_t          state;
  logic [AW:0]     rd_ptr;
  logic [WIDTH-1:0] pad_above;
  logic [WIDTH-1:0] pad_below;

`ifdef BORDER_REPLICATE_EN
  // Top edge replicates row 0 (read in FILL0); bottom edge keeps the last row in place
  assign pad_above = rom_data;
  assign pad_below = row_below;
`else
  assign pad_above = '0;
  assign pad_below = '0;
`endif

  // ROM address decode: follows rd_ptr while scanning, parked at 0 otherwise
  always_comb begin
    rom_addr = '0;
    if ((state == StFill0 || state == StFill1 || state == StEmit) && (rd_ptr < RowsP)) begin
      rom_addr = rd_ptr[AW-1:0];
    end
  end

  // Scan FSM with registered window outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      rd_ptr     <= '0;
      row_above  <= '0;
      row_center <= '0;
      row_below  <= '0;
      row_index  <= '0;
      win_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            state  <= StFill0;
            busy   <= 1'b1;
            rd_ptr <= '0;
          end
        end
        StFill0: begin
          row_center <= rom_data;
          row_above  <= pad_above;
          rd_ptr     <= (AW + 1)'(1);
          state      <= StFill1;
        end
        StFill1: begin
          row_below <= rom_data;
          rd_ptr    <= (AW + 1)'(2);
          row_index <= '0;
          win_valid <= 1'b1;
          state     <= StEmit;
        end
        StEmit: begin
          if (win_valid && win_ready) begin
            if (row_index == LastRow) begin
              win_valid <= 1'b0;
              done      <= 1'b1;
              state     <= StDone;
            end else begin
              row_above  <= row_center;
              row_center <= row_below;
              row_below  <= (rd_ptr < RowsP) ? rom_data : pad_below;
              row_index  <= row_index + AW'(1);
              rd_ptr     <= rd_ptr + (AW + 1)'(1);
            end
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
